// File: rtl/csa_seq_pkg.sv
// rtl/csa_seq_pkg.sv - shared types, constants and parameter checks for the wide sequential adder
package csa_seq_pkg;

    // Sequencer states: waiting for operands, adding slices, holding the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry-select block size inside the shared slice adder
    localparam int BLK_W = 4;

    // Slice width must split evenly into carry-select blocks
    function automatic bit slice_w_ok(input int slice_w);
        return (slice_w > 0) && ((slice_w % BLK_W) == 0);
    endfunction

    // A single beat would just be a plain adder; the sequencer needs at least two
    function automatic bit beats_ok(input int beats);
        return beats >= 2;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - combinational carry-select adder built from 4-bit blocks
module carry_select_adder
    import csa_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLK_W;

    // Each block precomputes its result for both possible incoming carries
    logic [NBLK-1:0][BLK_W:0] res0;
    logic [NBLK-1:0][BLK_W:0] res1;

    genvar g;
    for (g = 0; g < NBLK; g++) begin : g_blk
        assign res0[g] = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
        assign res1[g] = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]}
                         + {{BLK_W{1'b0}}, 1'b1};
    end

    // Ripple only the select signal through the blocks, picking the precomputed result
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < NBLK; i++) begin
            sum[i*BLK_W +: BLK_W] = c ? res1[i][BLK_W-1:0] : res0[i][BLK_W-1:0];
            c                     = c ? res1[i][BLK_W] : res0[i][BLK_W];
        end
        cout = c;
    end

endmodule

// File: rtl/csa_wide_add_seq.sv
// rtl/csa_wide_add_seq.sv - wide adder time-sharing one carry-select slice over several beats
module csa_wide_add_seq
    import csa_seq_pkg::*;
#(
    parameter  int SLICE_W = 64,
    parameter  int BEATS   = 4,
    localparam int W       = SLICE_W * BEATS,
    localparam int CNT_W   = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [CNT_W-1:0] beat_idx
);

    if (!slice_w_ok(SLICE_W)) begin : g_bad_slice_w
        $error("csa_wide_add_seq: SLICE_W must be a positive multiple of 4");
    end
    if (!beats_ok(BEATS)) begin : g_bad_beats
        $error("csa_wide_add_seq: BEATS must be at least 2");
    end

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t           state;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     result;
    logic             carry_reg;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic [W-1:0]       result_next;

    assign a_slice = op_a[int'(beat_idx)*SLICE_W +: SLICE_W];
    assign b_slice = op_b[int'(beat_idx)*SLICE_W +: SLICE_W];

    carry_select_adder #(
        .WIDTH (SLICE_W)
    ) u_slice_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Working result with the current beat's slice merged in
    always_comb begin
        result_next = result;
        result_next[int'(beat_idx)*SLICE_W +: SLICE_W] = slice_sum;
    end

    // Sequencer: accept operands, add one slice per edge, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            beat_idx  <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            carry_reg <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a      <= in_a;
                        op_b      <= in_b;
                        carry_reg <= in_cin;
                        beat_idx  <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    result    <= result_next;
                    carry_reg <= slice_cout;
                    if (beat_idx == LAST_BEAT) begin
                        out_sum   <= result_next;
                        out_cout  <= slice_cout;
                        beat_idx  <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        beat_idx <= beat_idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    beat_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// tb/tb_csa_wide_add_seq.sv - scoreboard bench for the wide sequential carry-select adder
module tb_csa_wide_add_seq;

    localparam int SLICE_W = 64;
    localparam int BEATS   = 4;
    localparam int W       = SLICE_W * BEATS;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic             busy;
    logic [CNT_W-1:0] beat_idx;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [W:0] sb[$];

    csa_wide_add_seq #(
        .SLICE_W (SLICE_W),
        .BEATS   (BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .beat_idx  (beat_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; the expected result is queued at the accept edge
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           output bit ok, output int acc_cycle);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        ok       = 1'b0;
        acc_cycle = -1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                sb.push_back(model(a, b, c));
                step();
                ok = 1'b1;
                acc_cycle = cycle;
                break;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
        checks++; if (beat_idx !== '0) begin errors++; $display("FAIL reset_beat_idx: got %0d want 0", beat_idx); end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] a;
        logic [W:0]   exp;
        bit ok;
        int acc;
        a = '1;
        out_ready = 1'b1;
        send_op(a, 256'd1, 1'b0, ok, acc);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL chain_accept: got %b want 1", ok); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chain_busy: got %b want 1", busy); end
        for (int k = 0; k < BEATS; k++) begin
            checks++; if (beat_idx !== CNT_W'(k)) begin errors++; $display("FAIL chain_beat_idx: got %0d want %0d", beat_idx, k); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_early_valid beat %0d: got %b want 0", k, out_valid); end
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL chain_latency: out_valid got %b want 1 after %0d edges", out_valid, BEATS); end
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL chain_sb_empty: got 0 entries want 1"); end
        else begin
            exp = sb.pop_front();
            checks++; if (out_sum !== exp[W-1:0]) begin errors++; $display("FAIL chain_sum: got %h want %h", out_sum, exp[W-1:0]); end
            checks++; if (out_cout !== exp[W]) begin errors++; $display("FAIL chain_cout: got %b want %b", out_cout, exp[W]); end
        end
        checks++; if (out_sum !== '0 || out_cout !== 1'b1) begin errors++; $display("FAIL chain_const: got %b/%h want 1/0", out_cout, out_sum); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_handshake_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL chain_handshake_ready: got %b want 1", in_ready); end
        checks++; if (out_sum !== '0 || out_cout !== 1'b1) begin errors++; $display("FAIL chain_hold_after: got %b/%h want 1/0", out_cout, out_sum); end
    endtask

    task automatic test_small_ops();
        logic [W-1:0] a;
        logic [W-1:0] e;
        logic [W:0]   exp;
        bit ok;
        int acc;
        out_ready = 1'b1;
        send_op('0, '0, 1'b1, ok, acc);
        wait_result(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cin_only_timeout: got %b want 1", ok); end
        exp = sb.pop_front();
        checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL cin_only_model: got %b/%h want %h", out_cout, out_sum, exp); end
        checks++; if (out_sum !== 256'd1 || out_cout !== 1'b0) begin errors++; $display("FAIL cin_only_const: got %b/%h want 0/1", out_cout, out_sum); end
        step();
        a = '0;
        a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        e = '0;
        e[64] = 1'b1;
        send_op(a, 256'd1, 1'b0, ok, acc);
        wait_result(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL slice_carry_timeout: got %b want 1", ok); end
        exp = sb.pop_front();
        checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL slice_carry_model: got %b/%h want %h", out_cout, out_sum, exp); end
        checks++; if (out_sum !== e || out_cout !== 1'b0) begin errors++; $display("FAIL slice_carry_const: got %b/%h want 0/%h", out_cout, out_sum, e); end
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic [W:0]   exp;
        bit ok;
        bit stable;
        int acc;
        out_ready = 1'b0;
        send_op(rand_wide(), rand_wide(), 1'b1, ok, acc);
        wait_result(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %b want 1", ok); end
        exp = sb.pop_front();
        checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL bp_first_result: got %b/%h want %h", out_cout, out_sum, exp); end
        held = out_sum;
        in_a = rand_wide();
        in_b = rand_wide();
        in_cin = 1'b0;
        in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_sum !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
            step();
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold: got stable=%b want 1 (sum %h valid %b ready %b)", stable, out_sum, out_valid, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b want 0 1", out_valid, in_ready); end
        sb.push_back(model(in_a, in_b, in_cin));
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got busy %b ready %b want 1 0", busy, in_ready); end
        wait_result(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_second_timeout: got %b want 1", ok); end
        exp = sb.pop_front();
        checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL bp_second_result: got %b/%h want %h", out_cout, out_sum, exp); end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] exp;
        bit ok;
        bit quiet;
        int acc;
        out_ready = 1'b1;
        send_op(256'd5, 256'd7, 1'b0, ok, acc);
        step();
        step();
        checks++; if (beat_idx !== 2'd2) begin errors++; $display("FAIL rst_mid_beat: got %0d want 2", beat_idx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || beat_idx !== '0) begin
            errors++; $display("FAIL rst_mid_state: got ready %b busy %b valid %b beat %0d want 1 0 0 0", in_ready, busy, out_valid, beat_idx);
        end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rst_mid_stale: got out_valid after reset, want none"); end
        send_op(256'd5, 256'd7, 1'b0, ok, acc);
        wait_result(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_after_timeout: got %b want 1", ok); end
        exp = sb.pop_front();
        checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL rst_after_model: got %b/%h want %h", out_cout, out_sum, exp); end
        checks++; if (out_sum !== 256'd12 || out_cout !== 1'b0) begin errors++; $display("FAIL rst_after_const: got %b/%h want 0/c", out_cout, out_sum); end
        step();
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        logic [W:0] exp;
        bit ok;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_a = rand_wide();
            in_b = rand_wide();
            in_cin = 1'($urandom_range(0, 1));
            if (in_ready) begin
                sb.push_back(model(in_a, in_b, in_cin));
                accepts.push_back(cycle + 1);
            end
            if (out_valid) begin
                checks++; if (sb.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got out_valid with empty scoreboard"); end
                else begin
                    exp = sb.pop_front();
                    checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL b2b_result: got %b/%h want %h", out_cout, out_sum, exp); end
                end
            end
            step();
        end
        in_valid = 1'b0;
        while (sb.size() != 0) begin
            wait_result(ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_drain_timeout: got %b want 1", ok); sb.delete(); break; end
            exp = sb.pop_front();
            checks++; if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL b2b_drain_result: got %b/%h want %h", out_cout, out_sum, exp); end
            step();
        end
        checks++; if (accepts.size() < 5) begin errors++; $display("FAIL b2b_accept_count: got %0d want >=5", accepts.size()); end
        for (int i = 1; i < accepts.size(); i++) begin
            checks++; if (accepts[i] - accepts[i-1] !== 6) begin errors++; $display("FAIL b2b_spacing: got %0d want 6", accepts[i] - accepts[i-1]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_small_ops();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
